// File: rtl/adc_frame_packer.sv
// Packs ADC samples MSB-first into WORD_W-bit words for the TLP data FIFO,
// interleaving header words and producing a per-frame optical start pulse.
module adc_frame_packer #(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 12,
  parameter int WORD_W    = 64,
  parameter int TLP_WORDS = 15
) (
  input  logic                         InputClock,
  input  logic                         rst,
  input  logic [NUM_CH*SAMPLE_W-1:0]   adc_in,
  input  logic                         cfg_enable,
  input  logic [12:0]                  cfg_frame_len,
  input  logic [8:0]                   cfg_pulse_offset,
  input  logic [6:0]                   cfg_pulse_width,
  input  logic [2:0]                   cfg_ch_sel,
  input  logic                         cfg_auto_ch,
  input  logic                         cfg_pack_mode,
  input  logic                         cfg_test_mode,
  input  logic [15:0]                  cfg_buf_len_tlps,
  input  logic                         cfg_clr_ovf,
  input  logic                         fifo_full,
  output logic [WORD_W-1:0]            TLPData,
  output logic                         DataWriteEnable,
  output logic [39:0]                  TLPHeader,
  output logic                         HeaderWriteEnable,
  output logic                         StartPulse,
  output logic                         overflow_flag
);

  localparam int LANES_B = WORD_W / 8;
  localparam int LANES_S = WORD_W / SAMPLE_W;
  localparam int PAD_B   = WORD_W - LANES_B * 8;
  localparam int PAD_S   = WORD_W - LANES_S * SAMPLE_W;
  localparam int LANE_IW = $clog2(LANES_B + 1);
  localparam int TW      = $clog2(TLP_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DROP, GAP} state_t;

  state_t               state;
  state_t               next_state;
  logic                 pack_mode;
  logic [LANE_IW-1:0]   lane_idx;
  logic [12:0]          frame_word_cnt;
  logic [20:0]          tick_cnt;
  logic [7:0]           test_cnt;
  logic [WORD_W-1:0]    word_acc;
  logic [TW-1:0]        tlp_word_cnt;
  logic [15:0]          tlp_cnt;
  logic [15:0]          buf_cnt;

  logic                 active;
  logic [4:0]           lane_w;
  logic [LANE_IW-1:0]   last_lane;
  logic                 word_done;
  logic [12:0]          frame_len_eff;
  logic                 frame_last;
  logic [7:0]           ch_num;
  logic [SAMPLE_W-1:0]  raw_sample;
  logic [15:0]          lane_val;
  logic [WORD_W-1:0]    acc_next;
  logic [WORD_W-1:0]    word_out;
  logic                 write_word;
  logic                 ovf_set;
  logic                 tlp_wrap;
  logic [9:0]           pulse_end;
  logic                 pulse_on;

  // Lane geometry follows the pack mode latched at the start of the frame.
  always_comb begin
    active        = (state == RUN) || (state == DROP);
    lane_w        = pack_mode ? 5'(SAMPLE_W) : 5'd8;
    last_lane     = pack_mode ? LANE_IW'(LANES_S - 1) : LANE_IW'(LANES_B - 1);
    word_done     = active && (lane_idx == last_lane);
    frame_len_eff = (cfg_frame_len == 13'd0) ? 13'd1 : cfg_frame_len;
    frame_last    = (({1'b0, frame_word_cnt} + 14'd1) == {1'b0, frame_len_eff});
    write_word    = (state == RUN) && word_done && !fifo_full;
    ovf_set       = (state == RUN) && word_done && fifo_full;
    tlp_wrap      = word_done && (tlp_word_cnt == TW'(TLP_WORDS - 1));
    pulse_end     = {1'b0, cfg_pulse_offset} + {3'b000, cfg_pulse_width};
    pulse_on      = active && (tick_cnt >= {12'd0, cfg_pulse_offset})
                           && (tick_cnt <= {11'd0, pulse_end});
  end

  always_comb begin
    ch_num = cfg_auto_ch ? (8'(lane_idx) % 8'(NUM_CH))
                         : ({5'd0, cfg_ch_sel} % 8'(NUM_CH));
    raw_sample = adc_in[SAMPLE_W-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_num == 8'(c)) raw_sample = adc_in[c*SAMPLE_W +: SAMPLE_W];
    end
    if (cfg_test_mode)  lane_val = {8'h00, test_cnt};
    else if (pack_mode) lane_val = 16'(raw_sample);
    else                lane_val = {8'h00, raw_sample[7:0]};
    acc_next = (word_acc << lane_w) | WORD_W'(lane_val);
    word_out = pack_mode ? (acc_next << PAD_S) : (acc_next << PAD_B);
  end

  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cfg_enable) next_state = RUN;
      RUN: begin
        if (word_done) begin
          if (frame_last)     next_state = GAP;
          else if (fifo_full) next_state = DROP;
        end
      end
      DROP: if (word_done && frame_last) next_state = GAP;
      GAP:  next_state = cfg_enable ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // DROP advances every counter like RUN so the host sees the tlp_cnt gap.
  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) begin
      pack_mode         <= 1'b0;
      lane_idx          <= '0;
      frame_word_cnt    <= '0;
      tick_cnt          <= '0;
      test_cnt          <= '0;
      word_acc          <= '0;
      tlp_word_cnt      <= '0;
      tlp_cnt           <= '0;
      buf_cnt           <= '0;
      TLPData           <= '0;
      DataWriteEnable   <= 1'b0;
      TLPHeader         <= '0;
      HeaderWriteEnable <= 1'b0;
      StartPulse        <= 1'b0;
      overflow_flag     <= 1'b0;
    end else begin
      DataWriteEnable   <= 1'b0;
      HeaderWriteEnable <= 1'b0;
      StartPulse        <= pulse_on;

      if (ovf_set)          overflow_flag <= 1'b1;
      else if (cfg_clr_ovf) overflow_flag <= 1'b0;

      case (state)
        IDLE: begin
          lane_idx       <= '0;
          frame_word_cnt <= '0;
          tick_cnt       <= '0;
          test_cnt       <= '0;
          word_acc       <= '0;
          tlp_word_cnt   <= '0;
          tlp_cnt        <= '0;
          buf_cnt        <= '0;
          if (cfg_enable) pack_mode <= cfg_pack_mode;
        end
        RUN, DROP: begin
          test_cnt <= test_cnt + 8'd1;
          if (tick_cnt != '1) tick_cnt <= tick_cnt + 21'd1;
          if (word_done) begin
            lane_idx       <= '0;
            word_acc       <= '0;
            frame_word_cnt <= frame_word_cnt + 13'd1;
            if (write_word) begin
              TLPData         <= word_out;
              DataWriteEnable <= 1'b1;
            end
            if (tlp_wrap) begin
              tlp_word_cnt <= '0;
              if (write_word) begin
                HeaderWriteEnable <= 1'b1;
                TLPHeader <= {buf_cnt, tlp_cnt, cfg_ch_sel, cfg_auto_ch,
                              cfg_pack_mode, 3'b111};
              end
              if (tlp_cnt == cfg_buf_len_tlps) begin
                tlp_cnt <= '0;
                buf_cnt <= buf_cnt + 16'd1;
              end else begin
                tlp_cnt <= tlp_cnt + 16'd1;
              end
            end else begin
              tlp_word_cnt <= tlp_word_cnt + TW'(1);
            end
          end else begin
            lane_idx <= lane_idx + LANE_IW'(1);
            word_acc <= acc_next;
          end
        end
        GAP: begin
          test_cnt       <= test_cnt + 8'd1;
          tick_cnt       <= '0;
          lane_idx       <= '0;
          frame_word_cnt <= '0;
          word_acc       <= '0;
          if (cfg_enable) pack_mode <= cfg_pack_mode;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed testbench for adc_frame_packer: records every write, header and
// pulse cycle, then compares against hand-computed expectations.
module tb_adc_frame_packer;

  localparam int NUM_CH    = 2;
  localparam int SAMPLE_W  = 12;
  localparam int WORD_W    = 64;
  localparam int TLP_WORDS = 15;

  logic                       InputClock = 1'b0;
  logic                       rst = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] adc_in = '0;
  logic                       cfg_enable = 1'b0;
  logic [12:0]                cfg_frame_len = '0;
  logic [8:0]                 cfg_pulse_offset = '0;
  logic [6:0]                 cfg_pulse_width = '0;
  logic [2:0]                 cfg_ch_sel = '0;
  logic                       cfg_auto_ch = 1'b0;
  logic                       cfg_pack_mode = 1'b0;
  logic                       cfg_test_mode = 1'b0;
  logic [15:0]                cfg_buf_len_tlps = '0;
  logic                       cfg_clr_ovf = 1'b0;
  logic                       fifo_full = 1'b0;
  logic [WORD_W-1:0]          TLPData;
  logic                       DataWriteEnable;
  logic [39:0]                TLPHeader;
  logic                       HeaderWriteEnable;
  logic                       StartPulse;
  logic                       overflow_flag;

  adc_frame_packer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WORD_W(WORD_W), .TLP_WORDS(TLP_WORDS)
  ) dut (
    .InputClock(InputClock), .rst(rst), .adc_in(adc_in),
    .cfg_enable(cfg_enable), .cfg_frame_len(cfg_frame_len),
    .cfg_pulse_offset(cfg_pulse_offset), .cfg_pulse_width(cfg_pulse_width),
    .cfg_ch_sel(cfg_ch_sel), .cfg_auto_ch(cfg_auto_ch),
    .cfg_pack_mode(cfg_pack_mode), .cfg_test_mode(cfg_test_mode),
    .cfg_buf_len_tlps(cfg_buf_len_tlps), .cfg_clr_ovf(cfg_clr_ovf),
    .fifo_full(fifo_full), .TLPData(TLPData), .DataWriteEnable(DataWriteEnable),
    .TLPHeader(TLPHeader), .HeaderWriteEnable(HeaderWriteEnable),
    .StartPulse(StartPulse), .overflow_flag(overflow_flag)
  );

  always #5 InputClock = ~InputClock;

  int cyc = 0;
  always @(posedge InputClock) cyc <= cyc + 1;

  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  logic [39:0] hdr_data[$];
  int          hdr_cyc[$];
  int          pulse_cyc[$];

  // Outputs are sampled on the falling edge, well away from the active edge.
  always @(negedge InputClock) begin
    if (!rst) begin
      if (DataWriteEnable) begin
        wr_data.push_back(TLPData);
        wr_cyc.push_back(cyc);
      end
      if (HeaderWriteEnable) begin
        hdr_data.push_back(TLPHeader);
        hdr_cyc.push_back(cyc);
      end
      if (StartPulse) pulse_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] wrData(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction
  function automatic int wrCyc(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1;
  endfunction
  function automatic logic [39:0] hdrData(input int i);
    if (i < hdr_data.size()) return hdr_data[i];
    return 40'hDE_ADBE_EFDE;
  endfunction
  function automatic int hdrCyc(input int i);
    if (i < hdr_cyc.size()) return hdr_cyc[i];
    return -1;
  endfunction
  function automatic int pulseCyc(input int i);
    if (i < pulse_cyc.size()) return pulse_cyc[i];
    return -1;
  endfunction

  // Resets the DUT, loads a configuration and enables acquisition; e is the
  // cycle count on the falling edge where enable is raised.
  task automatic applyStimulus(input bit pack, input bit test, input bit auto_c,
                               input logic [2:0] ch, input logic [12:0] flen,
                               input logic [8:0] off, input logic [6:0] wid,
                               input logic [15:0] buflen, input logic [23:0] adc,
                               output int e);
    @(negedge InputClock);
    rst              = 1'b1;
    cfg_enable       = 1'b0;
    cfg_pack_mode    = pack;
    cfg_test_mode    = test;
    cfg_auto_ch      = auto_c;
    cfg_ch_sel       = ch;
    cfg_frame_len    = flen;
    cfg_pulse_offset = off;
    cfg_pulse_width  = wid;
    cfg_buf_len_tlps = buflen;
    adc_in           = adc;
    fifo_full        = 1'b0;
    cfg_clr_ovf      = 1'b0;
    @(negedge InputClock);
    rst = 1'b0;
    wr_data.delete();
    wr_cyc.delete();
    hdr_data.delete();
    hdr_cyc.delete();
    pulse_cyc.delete();
    @(negedge InputClock);
    cfg_enable = 1'b1;
    e = cyc;
  endtask

  int e;

  initial begin
    $display("[TB] adc_frame_packer directed test start");

    #1 rst = 1'b1;
    #1;
    checkOutput("rst_data",  64'(TLPData), 64'd0);
    checkOutput("rst_dwe",   64'(DataWriteEnable), 64'd0);
    checkOutput("rst_hdr",   64'(TLPHeader), 64'd0);
    checkOutput("rst_hwe",   64'(HeaderWriteEnable), 64'd0);
    checkOutput("rst_pulse", 64'(StartPulse), 64'd0);
    checkOutput("rst_ovf",   64'(overflow_flag), 64'd0);

    // Mode 0, test counter, frame of 3 words, pulse at ticks 4..6.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 13'd3, 9'd4, 7'd2, 16'd0, 24'h0, e);
    repeat (40) @(negedge InputClock);
    checkOutput("t1_count", 64'(wr_data.size()), 64'd4);
    checkOutput("t1_w0",    wrData(0), 64'h0001020304050607);
    checkOutput("t1_w1",    wrData(1), 64'h08090A0B0C0D0E0F);
    checkOutput("t1_w2",    wrData(2), 64'h1011121314151617);
    checkOutput("t1_w3",    wrData(3), 64'h191A1B1C1D1E1F20);
    checkOutput("t1_lat",   64'(wrCyc(0) - e), 64'd9);
    checkOutput("t1_sp1",   64'(wrCyc(1) - wrCyc(0)), 64'd8);
    checkOutput("t1_sp2",   64'(wrCyc(2) - wrCyc(1)), 64'd8);
    checkOutput("t1_gap",   64'(wrCyc(3) - wrCyc(2)), 64'd9);
    checkOutput("t1_hdrs",  64'(hdr_data.size()), 64'd0);
    checkOutput("t1_pcnt",  64'(pulse_cyc.size()), 64'd6);
    checkOutput("t1_p0",    64'(pulseCyc(0) - e), 64'd6);
    checkOutput("t1_p2",    64'(pulseCyc(2) - e), 64'd8);
    checkOutput("t1_p3",    64'(pulseCyc(3) - e), 64'd31);
    checkOutput("t1_p5",    64'(pulseCyc(5) - e), 64'd33);

    // Mode 1 with 12-bit lanes, channel 0 fixed.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 13'd100, 9'd300, 7'd0, 16'd0,
                  {12'h123, 12'hABC}, e);
    repeat (18) @(negedge InputClock);
    checkOutput("t2_count", 64'(wr_data.size()), 64'd3);
    checkOutput("t2_w0",    wrData(0), 64'hABCABCABCABCABC0);
    checkOutput("t2_w2",    wrData(2), 64'hABCABCABCABCABC0);
    checkOutput("t2_lat",   64'(wrCyc(0) - e), 64'd6);
    checkOutput("t2_sp",    64'(wrCyc(1) - wrCyc(0)), 64'd5);

    // Round-robin channels, mode 0 keeps only the low byte of each sample.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 13'd100, 9'd300, 7'd0, 16'd0,
                  {12'h722, 12'h511}, e);
    repeat (12) @(negedge InputClock);
    checkOutput("t3_count", 64'(wr_data.size()), 64'd1);
    checkOutput("t3_w0",    wrData(0), 64'h1122112211221122);

    // Frame length 0 behaves as a one-word frame.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 13'd0, 9'd300, 7'd0, 16'd0, 24'h0, e);
    repeat (30) @(negedge InputClock);
    checkOutput("t4_count", 64'(wr_data.size()), 64'd3);
    checkOutput("t4_sp",    64'(wrCyc(1) - wrCyc(0)), 64'd9);
    checkOutput("t4_w1",    wrData(1), 64'h090A0B0C0D0E0F10);

    // Header cadence with a two-TLP buffer.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd1, 13'h1FFF, 9'd300, 7'd0, 16'd1,
                  {12'h0AA, 12'h055}, e);
    repeat (485) @(negedge InputClock);
    checkOutput("t5_words", 64'(wr_data.size()), 64'd60);
    checkOutput("t5_hdrs",  64'(hdr_data.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t5_hcyc%0d", k), 64'(hdrCyc(k)),
                  64'(wrCyc(15 * k + 14)));
    end
    checkOutput("t5_h0", 64'(hdrData(0)), 64'h00_0000_0027);
    checkOutput("t5_h1", 64'(hdrData(1)), 64'h00_0000_0127);
    checkOutput("t5_h2", 64'(hdrData(2)), 64'h00_0100_0027);
    checkOutput("t5_h3", 64'(hdrData(3)), 64'h00_0100_0127);

    // Backpressure on word 2 of a 4-word frame, clear raised in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 13'd4, 9'd300, 7'd0, 16'd0, 24'h0, e);
    repeat (16) @(negedge InputClock);
    fifo_full   = 1'b1;
    cfg_clr_ovf = 1'b1;
    @(negedge InputClock);
    fifo_full   = 1'b0;
    cfg_clr_ovf = 1'b0;
    repeat (27) @(negedge InputClock);
    checkOutput("t6_count", 64'(wr_data.size()), 64'd2);
    checkOutput("t6_w0",    wrData(0), 64'h0001020304050607);
    checkOutput("t6_c1",    64'(wrCyc(1) - e), 64'd42);
    checkOutput("t6_w1",    wrData(1), 64'h2122232425262728);
    checkOutput("t6_ovf",   64'(overflow_flag), 64'd1);
    cfg_clr_ovf = 1'b1;
    @(negedge InputClock);
    cfg_clr_ovf = 1'b0;
    checkOutput("t6_clr",   64'(overflow_flag), 64'd0);
    checkOutput("t6_hold",  64'(TLPData), 64'h2122232425262728);

    // Asynchronous reset mid-word clears outputs without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_data",  64'(TLPData), 64'd0);
    checkOutput("t7_dwe",   64'(DataWriteEnable), 64'd0);
    checkOutput("t7_pulse", 64'(StartPulse), 64'd0);
    checkOutput("t7_ovf",   64'(overflow_flag), 64'd0);
    @(negedge InputClock);
    rst = 1'b0;
    repeat (2) @(negedge InputClock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
